// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two dmem requesters, the arbiter and the dmem array.
// slave = arbiter side, master = requester/memory side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 11
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [31:0]       a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [31:0]       a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [31:0]       b_wdata;
    logic              b_gnt;
    logic              b_rvalid;
    logic [31:0]       b_rdata;

    logic              dm_w;
    logic              dm_r;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        output dm_w, dm_r, dm_addr, dm_wdata,
        input  dm_rdata
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  dm_w, dm_r, dm_addr, dm_wdata,
        output dm_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port dmem arbiter: one access slot per cycle, fixed A priority with B starvation
// relief; define DMEM_ARB_RR_EN for round-robin priority instead.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_arbiter_if.slave         bus,
    output logic [1:0]            state_dbg
);
    // Handshake: a request is accepted in the cycle where x_req && x_gnt; the requester
    // holds we/addr/wdata stable until then. gnt is combinational, rvalid is a one-cycle pulse.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_wdata;
    logic              b_prio;
    logic              a_gnt, b_gnt;
    logic              serving;
    logic              rd_a, rd_b;

`ifdef DMEM_ARB_RR_EN
    logic last_b;  // 1 when B won the most recent contention
    assign b_prio = ~last_b;
`else
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt;
    assign b_prio = (starve_cnt >= CNT_W'(STARVE_LIMIT));
`endif

    always_comb begin
        a_gnt   = 1'b0;
        b_gnt   = 1'b0;
        state_d = IDLE;
        if (!rst) begin
            if (bus.a_req && (!bus.b_req || !b_prio)) begin
                a_gnt = 1'b1;
            end else if (bus.b_req) begin
                b_gnt = 1'b1;
            end
        end
        if (a_gnt) begin
            state_d = SERVE_A;
        end else if (b_gnt) begin
            state_d = SERVE_B;
        end
    end

    // The slot after acceptance drives dmem from the captured request.
    assign serving      = (state_q != IDLE) && !rst;
    assign rd_a         = (state_q == SERVE_A) && !cap_we;
    assign rd_b         = (state_q == SERVE_B) && !cap_we;
    assign bus.a_gnt    = a_gnt;
    assign bus.b_gnt    = b_gnt;
    assign bus.dm_w     = serving && cap_we;
    assign bus.dm_r     = serving && !cap_we;
    assign bus.dm_addr  = cap_addr;
    assign bus.dm_wdata = cap_wdata;
    assign state_dbg    = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cap_we       <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
            bus.a_rvalid <= 1'b0;
            bus.b_rvalid <= 1'b0;
            bus.a_rdata  <= '0;
            bus.b_rdata  <= '0;
        end else begin
            state_q <= state_d;
            if (a_gnt) begin
                cap_we    <= bus.a_we;
                cap_addr  <= bus.a_addr;
                cap_wdata <= bus.a_wdata;
            end else if (b_gnt) begin
                cap_we    <= bus.b_we;
                cap_addr  <= bus.b_addr;
                cap_wdata <= bus.b_wdata;
            end
            bus.a_rvalid <= rd_a;
            bus.b_rvalid <= rd_b;
            if (rd_a) bus.a_rdata <= bus.dm_rdata;
            if (rd_b) bus.b_rdata <= bus.dm_rdata;
        end
    end

`ifdef DMEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_b <= 1'b1;
        end else if (bus.a_req && bus.b_req) begin
            last_b <= b_gnt;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (b_gnt) begin
            starve_cnt <= '0;
        end else if (bus.b_req && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, single-port reads/writes, back-to-back
// streams, contention priority and reset of an in-flight access.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] state_dbg;
  int total = 0;
  int bad = 0;
  logic [31:0] mem [0:2047];

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(11)) bus ();

  dmem_arbiter #(.STARVE_LIMIT(4), .ADDR_W(11)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // dmem model: combinational read, write on the edge; preloaded while in reset
  assign bus.dm_rdata = mem[bus.dm_addr];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 32'h0;
      mem[1] <= 32'h0000_0011;
      mem[2] <= 32'h0000_0022;
      mem[3] <= 32'h0000_0033;
      mem[5] <= 32'hDEAD_BEEF;
    end else if (bus.dm_w) begin
      mem[bus.dm_addr] <= bus.dm_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic req, input logic we, input logic [10:0] addr, input logic [31:0] wdata);
    bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
  endtask

  task automatic drive_b(input logic req, input logic we, input logic [10:0] addr, input logic [31:0] wdata);
    bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
  endtask

  initial begin
    logic [9:0] exp_a;
    rst = 1'b1;
    drive_a(1'b1, 1'b0, 11'd0, 32'h0);
    drive_b(1'b1, 1'b0, 11'd0, 32'h0);

    // reset: no grants or strobes while rst is high
    settle();
    check("rst_a_gnt", bus.a_gnt, 0);
    check("rst_b_gnt", bus.b_gnt, 0);
    check("rst_dm_w", bus.dm_w, 0);
    check("rst_dm_r", bus.dm_r, 0);
    tick();
    drive_a(1'b0, 1'b0, 11'd0, 32'h0);
    drive_b(1'b0, 1'b0, 11'd0, 32'h0);
    tick();
    rst = 1'b0;
    settle();
    check("rst_state", state_dbg, 0);
    check("rst_a_rvalid", bus.a_rvalid, 0);
    check("rst_b_rvalid", bus.b_rvalid, 0);
    check("rst_a_rdata", bus.a_rdata, 0);
    check("rst_b_rdata", bus.b_rdata, 0);
    check("rst_dm_addr", bus.dm_addr, 0);
    check("idle_dm_r", bus.dm_r, 0);
    tick();

    // A alone reads addr 5
    drive_a(1'b1, 1'b0, 11'd5, 32'h0);
    settle();
    check("rd5_a_gnt", bus.a_gnt, 1);
    check("rd5_b_gnt", bus.b_gnt, 0);
    tick();
    drive_a(1'b0, 1'b0, 11'd0, 32'h0);
    settle();
    check("rd5_state", state_dbg, 1);
    check("rd5_dm_r", bus.dm_r, 1);
    check("rd5_dm_w", bus.dm_w, 0);
    check("rd5_dm_addr", bus.dm_addr, 5);
    check("rd5_rvalid_early", bus.a_rvalid, 0);
    tick();
    settle();
    check("rd5_a_rvalid", bus.a_rvalid, 1);
    check("rd5_a_rdata", bus.a_rdata, 32'hDEAD_BEEF);
    check("rd5_idle_dm_r", bus.dm_r, 0);
    check("rd5_hold_addr", bus.dm_addr, 5);
    tick();
    settle();
    check("rd5_rvalid_drop", bus.a_rvalid, 0);
    check("rd5_rdata_hold", bus.a_rdata, 32'hDEAD_BEEF);
    tick();

    // A writes 0x1234 to addr 7, B reads addr 7 in the next slot
    drive_a(1'b1, 1'b1, 11'd7, 32'h0000_1234);
    settle();
    check("wr7_a_gnt", bus.a_gnt, 1);
    tick();
    drive_a(1'b0, 1'b0, 11'd0, 32'h0);
    drive_b(1'b1, 1'b0, 11'd7, 32'h0);
    settle();
    check("wr7_b_gnt", bus.b_gnt, 1);
    check("wr7_dm_w", bus.dm_w, 1);
    check("wr7_dm_r", bus.dm_r, 0);
    check("wr7_dm_addr", bus.dm_addr, 7);
    check("wr7_dm_wdata", bus.dm_wdata, 32'h0000_1234);
    tick();
    drive_b(1'b0, 1'b0, 11'd0, 32'h0);
    settle();
    check("wr7_state_b", state_dbg, 2);
    check("wr7_b_dm_r", bus.dm_r, 1);
    check("wr7_no_a_rvalid", bus.a_rvalid, 0);
    check("wr7_b_rvalid_early", bus.b_rvalid, 0);
    tick();
    settle();
    check("wr7_b_rvalid", bus.b_rvalid, 1);
    check("wr7_b_rdata", bus.b_rdata, 32'h0000_1234);
    check("wr7_a_rdata_hold", bus.a_rdata, 32'hDEAD_BEEF);
    tick();

    // B alone: three back-to-back reads of addrs 1,2,3
    drive_b(1'b1, 1'b0, 11'd1, 32'h0);
    settle();
    check("str_gnt0", bus.b_gnt, 1);
    tick();
    drive_b(1'b1, 1'b0, 11'd2, 32'h0);
    settle();
    check("str_gnt1", bus.b_gnt, 1);
    check("str_dm_addr1", bus.dm_addr, 1);
    tick();
    drive_b(1'b1, 1'b0, 11'd3, 32'h0);
    settle();
    check("str_gnt2", bus.b_gnt, 1);
    check("str_rvalid0", bus.b_rvalid, 1);
    check("str_rdata0", bus.b_rdata, 32'h0000_0011);
    tick();
    drive_b(1'b0, 1'b0, 11'd0, 32'h0);
    settle();
    check("str_rvalid1", bus.b_rvalid, 1);
    check("str_rdata1", bus.b_rdata, 32'h0000_0022);
    tick();
    settle();
    check("str_rvalid2", bus.b_rvalid, 1);
    check("str_rdata2", bus.b_rdata, 32'h0000_0033);
    tick();
    settle();
    check("str_rvalid_end", bus.b_rvalid, 0);
    tick();

    // both requesting continuously: priority pattern, bit i = A wins cycle i
`ifdef DMEM_ARB_RR_EN
    exp_a = 10'b0101010101;
`else
    exp_a = 10'b0111101111;
`endif
    drive_a(1'b1, 1'b0, 11'd0, 32'h0);
    drive_b(1'b1, 1'b0, 11'd0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      settle();
      check($sformatf("pri_a_gnt%0d", i), bus.a_gnt, exp_a[i]);
      check($sformatf("pri_b_gnt%0d", i), bus.b_gnt, !exp_a[i]);
      tick();
    end
    drive_a(1'b0, 1'b0, 11'd0, 32'h0);
    drive_b(1'b0, 1'b0, 11'd0, 32'h0);
    tick();
    tick();
    tick();

    // A then B write addr 9 in consecutive slots; later data survives
    drive_a(1'b1, 1'b1, 11'd9, 32'h0000_AAAA);
    settle();
    check("same_a_gnt", bus.a_gnt, 1);
    tick();
    drive_a(1'b0, 1'b0, 11'd0, 32'h0);
    drive_b(1'b1, 1'b1, 11'd9, 32'h0000_BBBB);
    settle();
    check("same_b_gnt", bus.b_gnt, 1);
    check("same_wdata_a", bus.dm_wdata, 32'h0000_AAAA);
    tick();
    drive_b(1'b0, 1'b0, 11'd0, 32'h0);
    drive_a(1'b1, 1'b0, 11'd9, 32'h0);
    settle();
    check("same_rd_gnt", bus.a_gnt, 1);
    check("same_wdata_b", bus.dm_wdata, 32'h0000_BBBB);
    tick();
    drive_a(1'b0, 1'b0, 11'd0, 32'h0);
    settle();
    check("same_dm_r", bus.dm_r, 1);
    check("same_dm_addr", bus.dm_addr, 9);
    tick();
    settle();
    check("same_a_rvalid", bus.a_rvalid, 1);
    check("same_a_rdata", bus.a_rdata, 32'h0000_BBBB);
    tick();

    // reset arrives in the slot after a write is granted
    drive_a(1'b1, 1'b1, 11'd12, 32'h0000_0055);
    settle();
    check("fly_a_gnt", bus.a_gnt, 1);
    tick();
    drive_a(1'b0, 1'b0, 11'd0, 32'h0);
    drive_b(1'b1, 1'b0, 11'd3, 32'h0);
    rst = 1'b1;
    settle();
    check("fly_rst_dm_w", bus.dm_w, 0);
    check("fly_rst_b_gnt", bus.b_gnt, 0);
    tick();
    drive_b(1'b0, 1'b0, 11'd0, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("fly_dm_w%0d", i), bus.dm_w, 0);
      check($sformatf("fly_dm_r%0d", i), bus.dm_r, 0);
      check($sformatf("fly_a_rvalid%0d", i), bus.a_rvalid, 0);
      check($sformatf("fly_b_rvalid%0d", i), bus.b_rvalid, 0);
      check($sformatf("fly_state%0d", i), state_dbg, 0);
      tick();
    end
    check("fly_a_rdata_clr", bus.a_rdata, 0);
    check("fly_b_rdata_clr", bus.b_rdata, 0);
    check("fly_dm_addr_clr", bus.dm_addr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
